// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - shared status-word layout for the external-port controller
package io_port_pkg;

    localparam int STAT_TXFULL  = 0;
    localparam int STAT_RXEMPTY = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_UNF     = 3;
    localparam int STAT_IRQEN   = 4;
    localparam int STAT_W       = 5;

    // Field order gives bit 4 down to bit 0, matching the STAT_* indices above.
    typedef struct packed {
        logic irq_en;
        logic unf;
        logic ovf;
        logic rx_empty;
        logic tx_full;
    } status_t;

endpackage

// File: rtl/port_fifo.sv
// rtl/port_fifo.sv - synchronous FIFO with combinational head, used for each TX and RX channel
module port_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   r,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      din,
    output logic [DATA_W-1:0]      dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // At full a simultaneous pop lets the push land in the slot being vacated.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/io_port_unit.sv
// rtl/io_port_unit.sv - CPU-side register decode over NUM_PORTS buffered TX/RX device channels
module io_port_unit
    import io_port_pkg::*;
#(
    parameter int  DATA_W     = 16,
    parameter int  NUM_PORTS  = 4,
    parameter int  FIFO_DEPTH = 4,
    localparam int PSEL_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        r,
    input  logic [PSEL_W-1:0]           port_sel,
    input  logic                        wr,
    input  logic                        rd,
    input  logic                        stat,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata,
    output logic                        rdata_valid,
    output logic [NUM_PORTS*DATA_W-1:0] tx_data,
    output logic [NUM_PORTS-1:0]        tx_valid,
    input  logic [NUM_PORTS-1:0]        tx_ready,
    input  logic [NUM_PORTS*DATA_W-1:0] rx_data,
    input  logic [NUM_PORTS-1:0]        rx_valid,
    output logic [NUM_PORTS-1:0]        rx_ready,
    output logic                        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_PORTS-1:0] w_sel_oh;
    logic                 w_sel_ok;
    logic                 w_dwr;
    logic                 w_drd;
    logic                 w_cwr;
    logic                 w_srd;

    logic [NUM_PORTS-1:0] w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [NUM_PORTS-1:0] w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [DATA_W-1:0]    w_tx_dout [NUM_PORTS];
    logic [DATA_W-1:0]    w_rx_dout [NUM_PORTS];
    logic [CW-1:0]        w_tx_cnt_unused [NUM_PORTS];
    logic [CW-1:0]        w_rx_cnt_unused [NUM_PORTS];

    logic [NUM_PORTS-1:0] r_ovf;
    logic [NUM_PORTS-1:0] r_unf;
    logic [NUM_PORTS-1:0] r_irq_en;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_rdata_valid;
    logic                 r_irq;

    status_t              w_stat;
    logic [DATA_W-1:0]    w_stat_word;
    logic [DATA_W-1:0]    w_rx_head;
    logic                 w_sel_rx_empty;

    // Out-of-range selects decode to no port, so writes vanish and reads see zero.
    always_comb begin
        w_sel_oh = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_sel_oh[p] = (port_sel == PSEL_W'(p));
        end
    end

    assign w_sel_ok = |w_sel_oh;
    assign w_dwr    = wr & ~stat;
    assign w_drd    = rd & ~stat;
    assign w_cwr    = wr & stat;
    assign w_srd    = rd & stat;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign w_tx_push[p] = w_dwr & w_sel_oh[p] & ~w_tx_full[p];
        assign w_tx_pop[p]  = ~w_tx_empty[p] & tx_ready[p];
        assign w_rx_push[p] = rx_valid[p] & ~w_rx_full[p];
        assign w_rx_pop[p]  = w_drd & w_sel_oh[p] & ~w_rx_empty[p];

        assign tx_data[p*DATA_W +: DATA_W] = w_tx_dout[p];
        assign tx_valid[p] = ~w_tx_empty[p];
        assign rx_ready[p] = ~w_rx_full[p];

        port_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
            .clk   (clk),
            .r     (r),
            .push  (w_tx_push[p]),
            .pop   (w_tx_pop[p]),
            .din   (wdata),
            .dout  (w_tx_dout[p]),
            .full  (w_tx_full[p]),
            .empty (w_tx_empty[p]),
            .count (w_tx_cnt_unused[p])
        );

        port_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
            .clk   (clk),
            .r     (r),
            .push  (w_rx_push[p]),
            .pop   (w_rx_pop[p]),
            .din   (rx_data[p*DATA_W +: DATA_W]),
            .dout  (w_rx_dout[p]),
            .full  (w_rx_full[p]),
            .empty (w_rx_empty[p]),
            .count (w_rx_cnt_unused[p])
        );
    end

    always_comb begin
        w_stat         = '0;
        w_rx_head      = '0;
        w_sel_rx_empty = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_sel_oh[p]) begin
                w_stat.irq_en   = r_irq_en[p];
                w_stat.unf      = r_unf[p];
                w_stat.ovf      = r_ovf[p];
                w_stat.rx_empty = w_rx_empty[p];
                w_stat.tx_full  = w_tx_full[p];
                w_rx_head       = w_rx_dout[p];
                w_sel_rx_empty  = w_rx_empty[p];
            end
        end
        w_stat_word            = '0;
        w_stat_word[STAT_W-1:0] = w_stat;
    end

    // Sets come after the status-read clear so a same-cycle event is not lost.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_ovf    <= '0;
            r_unf    <= '0;
            r_irq_en <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_srd && w_sel_oh[p]) begin
                    r_ovf[p] <= 1'b0;
                    r_unf[p] <= 1'b0;
                end
                if (w_dwr && w_sel_oh[p] && w_tx_full[p])  r_ovf[p] <= 1'b1;
                if (w_drd && w_sel_oh[p] && w_rx_empty[p]) r_unf[p] <= 1'b1;
                if (w_cwr && w_sel_oh[p])                  r_irq_en[p] <= wdata[0];
            end
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_rdata_valid <= rd;
            if (rd) begin
                if (!w_sel_ok)           r_rdata <= '0;
                else if (stat)           r_rdata <= w_stat_word;
                else if (w_sel_rx_empty) r_rdata <= '0;
                else                     r_rdata <= w_rx_head;
            end
            r_irq <= |(~w_rx_empty & r_irq_en);
        end
    end

    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign irq         = r_irq;

endmodule

// File: tb/tb_io_port_unit.sv
// tb/tb_io_port_unit.sv - directed and random checks of io_port_unit against a queue-based model
module tb_io_port_unit;

    localparam int DW    = 16;
    localparam int NP    = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             r;
    logic [1:0]       port_sel;
    logic             wr, rd, stat;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    rdata;
    logic             rdata_valid;
    logic [NP*DW-1:0] tx_data;
    logic [NP-1:0]    tx_valid;
    logic [NP-1:0]    tx_ready;
    logic [NP*DW-1:0] rx_data;
    logic [NP-1:0]    rx_valid;
    logic [NP-1:0]    rx_ready;
    logic             irq;

    always #5 clk = ~clk;

    io_port_unit #(.DATA_W(DW), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .r           (r),
        .port_sel    (port_sel),
        .wr          (wr),
        .rd          (rd),
        .stat        (stat),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .irq         (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] m_tx [NP][$];
    logic [DW-1:0] m_rx [NP][$];
    logic [NP-1:0] m_ovf, m_unf, m_ien;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_tx[p].delete();
            m_rx[p].delete();
        end
        m_ovf = '0;
        m_unf = '0;
        m_ien = '0;
    endtask

    task automatic idle_inputs();
        wr = 0; rd = 0; stat = 0; port_sel = 0; wdata = 0;
        tx_ready = 0; rx_valid = 0; rx_data = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rdata"},   rdata, 0);
        check_eq({tag, "_rvalid"},  rdata_valid, 0);
        check_eq({tag, "_irq"},     irq, 0);
        check_eq({tag, "_txvalid"}, tx_valid, 0);
        check_eq({tag, "_rxready"}, rx_ready, 4'hF);
    endtask

    // One bus cycle: drive, check combinational outputs, advance the model, check registered outputs.
    task automatic cycle(input logic c_wr, input logic c_rd, input logic c_stat, input logic [1:0] c_sel,
                         input logic [DW-1:0] c_wd, input logic [NP-1:0] c_txr,
                         input logic [NP-1:0] c_rxv, input logic [NP*DW-1:0] c_rxd);
        logic [DW-1:0] exp_rd;
        logic          exp_irq;
        logic [NP-1:0] exp_txv, exp_rxr;
        logic          tfull, rfull, rempty;
        @(negedge clk);
        wr = c_wr; rd = c_rd; stat = c_stat; port_sel = c_sel; wdata = c_wd;
        tx_ready = c_txr; rx_valid = c_rxv; rx_data = c_rxd;
        #1;
        exp_irq = 1'b0;
        for (int p = 0; p < NP; p++) begin
            exp_txv[p] = (m_tx[p].size() != 0);
            exp_rxr[p] = (m_rx[p].size() != DEPTH);
            if (m_rx[p].size() != 0 && m_ien[p]) exp_irq = 1'b1;
        end
        check_eq("tx_valid", tx_valid, exp_txv);
        check_eq("rx_ready", rx_ready, exp_rxr);
        for (int p = 0; p < NP; p++) begin
            if (exp_txv[p]) check_eq($sformatf("tx_data%0d", p), tx_data[p*DW +: DW], m_tx[p][0]);
        end
        exp_rd = '0;
        if (c_rd && c_stat)
            exp_rd = {11'd0, m_ien[c_sel], m_unf[c_sel], m_ovf[c_sel],
                      (m_rx[c_sel].size() == 0), (m_tx[c_sel].size() == DEPTH)};
        else if (c_rd && m_rx[c_sel].size() != 0)
            exp_rd = m_rx[c_sel][0];
        if (c_rd && c_stat) begin
            m_ovf[c_sel] = 1'b0;
            m_unf[c_sel] = 1'b0;
        end
        if (c_wr && c_stat) m_ien[c_sel] = c_wd[0];
        for (int p = 0; p < NP; p++) begin
            tfull  = (m_tx[p].size() == DEPTH);
            rfull  = (m_rx[p].size() == DEPTH);
            rempty = (m_rx[p].size() == 0);
            if (m_tx[p].size() != 0 && c_txr[p]) void'(m_tx[p].pop_front());
            if (c_wr && !c_stat && c_sel == p) begin
                if (tfull) m_ovf[p] = 1'b1;
                else       m_tx[p].push_back(c_wd);
            end
            if (c_rd && !c_stat && c_sel == p) begin
                if (rempty) m_unf[p] = 1'b1;
                else        void'(m_rx[p].pop_front());
            end
            if (c_rxv[p] && !rfull) m_rx[p].push_back(c_rxd[p*DW +: DW]);
        end
        @(posedge clk);
        #1;
        check_eq("rdata_valid", rdata_valid, c_rd);
        if (c_rd) check_eq("rdata", rdata, exp_rd);
        check_eq("irq", irq, exp_irq);
    endtask

    task automatic idle_cycle(input logic [NP-1:0] c_txr);
        cycle(0, 0, 0, 0, 0, c_txr, 0, 0);
    endtask

    initial begin
        logic [DW-1:0] nxt;
        idle_inputs();
        model_reset();
        r = 1'b0;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        r = 1'b1;

        // TX fill on port 2 with the device stalled, then overflow.
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 2, 16'hA001 + DW'(i), 0, 0, 0);
        check_eq("t2_txvalid2", tx_valid[2], 1);
        cycle(1, 0, 0, 2, 16'hBEEF, 0, 0, 0);
        cycle(0, 1, 1, 2, 0, 0, 0, 0);
        check_eq("t2_stat1", rdata, 16'h0007);
        cycle(0, 1, 1, 2, 0, 0, 0, 0);
        check_eq("t2_stat2", rdata, 16'h0003);

        // Back-to-back drain to the device.
        for (int i = 0; i < 4; i++) begin
            check_eq("t3_head", tx_data[2*DW +: DW], 16'hA001 + DW'(i));
            idle_cycle(4'b0100);
        end
        check_eq("t3_txvalid2", tx_valid[2], 0);

        // RX on port 0 and underflow.
        cycle(0, 0, 0, 0, 0, 0, 4'b0001, 64'h1234);
        cycle(0, 0, 0, 0, 0, 0, 4'b0001, 64'h5678);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check_eq("t4_rd1", rdata, 16'h1234);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check_eq("t4_rd2", rdata, 16'h5678);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check_eq("t4_rd3", rdata, 16'h0000);
        cycle(0, 1, 1, 0, 0, 0, 0, 0);
        check_eq("t4_stat", rdata, 16'h000A);

        // Port 1 RX full with the device still offering; reads and pushes overlap.
        nxt = 16'h5100;
        for (int i = 0; i < 10; i++) begin
            if (m_rx[1].size() == DEPTH || i < 4)
                cycle(0, (i >= 4), 0, 1, 0, 0, 4'b0010, {32'd0, nxt, 16'd0});
            else
                cycle(0, 1, 0, 1, 0, 0, 4'b0010, {32'd0, nxt, 16'd0});
            if (i < 4) nxt = nxt + 1;
            else if (m_rx[1].size() <= DEPTH && rx_ready[1] !== 1'bx) nxt = (m_rx[1].size() != 0) ? m_rx[1][m_rx[1].size()-1] + 1 : nxt;
        end
        check_eq("t5_rd_order", rdata, 16'h5105);
        while (m_rx[1].size() != 0) cycle(0, 1, 0, 1, 0, 0, 0, 0);
        check_eq("t5_empty", rx_ready[1], 1);

        // Interrupt enable / disable on port 3.
        cycle(1, 0, 1, 3, 16'h0001, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 4'b1000, {16'hC0DE, 48'd0});
        check_eq("t6_irq_lat", irq, 0);
        idle_cycle(0);
        check_eq("t6_irq_on", irq, 1);
        cycle(0, 1, 0, 3, 0, 0, 0, 0);
        idle_cycle(0);
        check_eq("t6_irq_off", irq, 0);
        cycle(1, 0, 1, 3, 16'h0000, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 4'b1000, {16'hC0DF, 48'd0});
        idle_cycle(0);
        idle_cycle(0);
        check_eq("t6_irq_masked", irq, 0);
        cycle(0, 1, 0, 3, 0, 0, 0, 0);

        // Random traffic with an asynchronous reset part-way through.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                @(negedge clk);
                idle_inputs();
                r = 1'b0;
                #1;
                check_reset_outputs("midrst");
                model_reset();
                @(negedge clk);
                r = 1'b1;
            end
            cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                  2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom), 4'($urandom),
                  {32'($urandom), 32'($urandom)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
